// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, FSM states, tag-field layout and word-merge helper
package dcache_pkg;
   localparam int ADDR_W    = 32;
   localparam int INDEX_W   = 4;
   localparam int OFFSET_W  = 5;
   localparam int LINE_W    = 256;
   localparam int WORD_W    = 32;
   localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
   localparam int TAGF_W    = TAG_W + 2;
   localparam int VALID_BIT = TAG_W + 1;
   localparam int DIRTY_BIT = TAG_W;
   localparam int WSEL_W    = OFFSET_W - 2;
   typedef enum logic [2:0] {S_IDLE, S_MISS, S_WRITEBACK, S_REFILL, S_REFILL_DONE} state_t;
   function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                    input logic [WSEL_W-1:0] sel,
                                                    input logic [WORD_W-1:0] data);
      logic [LINE_W-1:0] r;
      r = line;
      r[sel*WORD_W +: WORD_W] = data;
      return r;
   endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU, memory and SRAM signals of the data-cache controller
interface dcache_if;
   import dcache_pkg::*;
   logic [ADDR_W-1:0] cpu_addr_i;
   logic [WORD_W-1:0] cpu_data_i;
   logic              cpu_read_i;
   logic              cpu_write_i;
   logic [WORD_W-1:0] cpu_data_o;
   logic              cpu_stall_o;
   logic              mem_enable_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_data_o;
   logic [LINE_W-1:0] mem_data_i;
   logic              mem_ack_i;
   logic              cache_enable_o;
   logic              cache_write_o;
   logic [INDEX_W-1:0] cache_addr_o;
   logic [TAGF_W-1:0] cache_tag_o;
   logic [LINE_W-1:0] cache_data_o;
   logic [TAGF_W-1:0] cache_tag_i;
   logic [LINE_W-1:0] cache_data_i;
   logic              cache_hit_i;
   modport master (
      input  cpu_addr_i, cpu_data_i, cpu_read_i, cpu_write_i,
      output cpu_data_o, cpu_stall_o,
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      input  mem_data_i, mem_ack_i,
      output cache_enable_o, cache_write_o, cache_addr_o, cache_tag_o, cache_data_o,
      input  cache_tag_i, cache_data_i, cache_hit_i
   );
   modport slave (
      output cpu_addr_i, cpu_data_i, cpu_read_i, cpu_write_i,
      input  cpu_data_o, cpu_stall_o,
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      output mem_data_i, mem_ack_i,
      input  cache_enable_o, cache_write_o, cache_addr_o, cache_tag_o, cache_data_o,
      output cache_tag_i, cache_data_i, cache_hit_i
   );
endinterface

// File: rtl/dcache_word_merge.sv
// dcache_word_merge: replaces one word of a line and extracts the selected word
module dcache_word_merge
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] i_line,
   input  logic [WSEL_W-1:0] i_sel,
   input  logic [WORD_W-1:0] i_data,
   output logic [LINE_W-1:0] o_line,
   output logic [WORD_W-1:0] o_word
);
   assign o_line = merge_word(i_line, i_sel, i_data);
   assign o_word = i_line[i_sel*WORD_W +: WORD_W];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: hit service, store merge and write-back/refill FSM for a 2-way dcache
module dcache_controller
   import dcache_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_i,
   dcache_if.master bus
);
   state_t              r_state, w_next;
   logic [TAG_W-1:0]    r_victim_tag;
   logic [LINE_W-1:0]   r_victim_data, r_refill_data;
   logic [TAG_W-1:0]    w_tag;
   logic [INDEX_W-1:0]  w_index;
   logic [WSEL_W-1:0]   w_sel;
   logic                w_req, w_hit, w_wr_hit, w_unused;
   logic [LINE_W-1:0]   w_merged;
   logic [WORD_W-1:0]   w_word;
   assign w_tag    = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
   assign w_index  = bus.cpu_addr_i[OFFSET_W +: INDEX_W];
   assign w_sel    = bus.cpu_addr_i[2 +: WSEL_W];
   assign w_unused = ^bus.cpu_addr_i[1:0];
   assign w_req    = bus.cpu_read_i | bus.cpu_write_i;
   assign w_hit    = w_req & bus.cache_hit_i;
   assign w_wr_hit = w_hit & bus.cpu_write_i;
   dcache_word_merge u_merge (
      .i_line (bus.cache_data_i),
      .i_sel  (w_sel),
      .i_data (bus.cpu_data_i),
      .o_line (w_merged),
      .o_word (w_word)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_victim_tag  <= '0;
         r_victim_data <= '0;
         r_refill_data <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_MISS) begin
            r_victim_tag  <= bus.cache_tag_i[TAG_W-1:0];
            r_victim_data <= bus.cache_data_i;
         end
         if (r_state == S_REFILL && bus.mem_ack_i) r_refill_data <= bus.mem_data_i;
      end
   end
   always_comb begin
      w_next             = r_state;
      bus.cpu_stall_o    = 1'b1;
      bus.cpu_data_o     = '0;
      bus.mem_enable_o   = 1'b0;
      bus.mem_write_o    = 1'b0;
      bus.mem_addr_o     = '0;
      bus.mem_data_o     = '0;
      bus.cache_enable_o = 1'b0;
      bus.cache_write_o  = 1'b0;
      bus.cache_addr_o   = w_index;
      bus.cache_tag_o    = {1'b1, 1'b0, w_tag};
      bus.cache_data_o   = w_merged;
      case (r_state)
         S_IDLE: begin
            bus.cpu_stall_o    = w_req & ~bus.cache_hit_i;
            bus.cpu_data_o     = w_hit ? w_word : '0;
            bus.cache_enable_o = w_req;
            bus.cache_write_o  = w_wr_hit;
            bus.cache_tag_o    = {1'b1, w_wr_hit, w_tag};
            w_next             = (w_req & ~bus.cache_hit_i) ? S_MISS : S_IDLE;
         end
         S_MISS:
            w_next = (bus.cache_tag_i[VALID_BIT] & bus.cache_tag_i[DIRTY_BIT]) ? S_WRITEBACK : S_REFILL;
         S_WRITEBACK: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_write_o  = 1'b1;
            bus.mem_addr_o   = {r_victim_tag, w_index, {OFFSET_W{1'b0}}};
            bus.mem_data_o   = r_victim_data;
            w_next           = bus.mem_ack_i ? S_REFILL : S_WRITEBACK;
         end
         S_REFILL: begin
            bus.mem_enable_o = 1'b1;
            bus.mem_addr_o   = {w_tag, w_index, {OFFSET_W{1'b0}}};
            w_next           = bus.mem_ack_i ? S_REFILL_DONE : S_REFILL;
         end
         S_REFILL_DONE: begin
            bus.cache_enable_o = 1'b1;
            bus.cache_write_o  = 1'b1;
            bus.cache_data_o   = r_refill_data;
            w_next             = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed checks of hit, store merge, clean/dirty miss and reset abort
module tb_dcache_controller;
   import dcache_pkg::*;
   typedef logic [LINE_W-1:0] v_t;
   localparam int LAT = 5;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   dcache_if bus();
   dcache_controller dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   int n_checks = 0;
   int n_errors = 0;
   task automatic check(input string tag, input v_t got, input v_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic v_t line_of(input logic [31:0] a);
      v_t l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hA000_0000 | a | 32'(i);
      if (a == 32'h40) l[95:64] = 32'hDEAD_BEEF;
      return l;
   endfunction
   logic [TAGF_W-1:0] s_tag [16][2];
   logic [LINE_W-1:0] s_data [16][2];
   logic              s_lru [16];
   logic              sram_clr;
   int                n_wr = 0;
   logic [3:0]        l_idx;
   logic [TAG_W-1:0]  l_tag;
   logic              l_h0, l_h1, l_way;
   always_comb begin
      l_idx = bus.cpu_addr_i[8:5];
      l_tag = bus.cpu_addr_i[31:9];
      l_h0  = s_tag[l_idx][0][VALID_BIT] && s_tag[l_idx][0][TAG_W-1:0] == l_tag;
      l_h1  = s_tag[l_idx][1][VALID_BIT] && s_tag[l_idx][1][TAG_W-1:0] == l_tag;
      l_way = l_h0 ? 1'b0 : l_h1 ? 1'b1 : s_lru[l_idx];
   end
   assign bus.cache_hit_i  = l_h0 | l_h1;
   assign bus.cache_tag_i  = s_tag[l_idx][l_way];
   assign bus.cache_data_i = s_data[l_idx][l_way];
   always @(posedge clk) begin
      if (sram_clr) begin
         for (int s = 0; s < 16; s++) begin
            s_lru[s] <= 1'b0;
            for (int w = 0; w < 2; w++) begin
               s_tag[s][w]  <= '0;
               s_data[s][w] <= '0;
            end
         end
      end else if (bus.cache_enable_o) begin
         if (bus.cache_write_o) begin
            s_tag[bus.cache_addr_o][l_way]  <= bus.cache_tag_o;
            s_data[bus.cache_addr_o][l_way] <= bus.cache_data_o;
            n_wr <= n_wr + 1;
         end
         if (bus.cache_write_o || bus.cache_hit_i) s_lru[bus.cache_addr_o] <= ~l_way;
      end
   end
   logic              auto_mem, man_ack, m_ack;
   logic [LINE_W-1:0] m_rdata, wb_data;
   logic [31:0]       wb_addr, rd_addr;
   int                cnt = 0;
   int                n_wb = 0;
   assign bus.mem_ack_i  = auto_mem ? m_ack : man_ack;
   assign bus.mem_data_i = m_rdata;
   // memory answers LAT cycles after a request is first seen
   always @(negedge clk) begin
      if (rst || !auto_mem) begin
         m_ack = 1'b0;
         cnt   = 0;
      end else if (m_ack) begin
         m_ack = 1'b0;
         cnt   = bus.mem_enable_o ? 1 : 0;
      end else if (bus.mem_enable_o) begin
         cnt++;
         if (cnt == LAT) begin
            m_ack = 1'b1;
            if (bus.mem_write_o) begin
               n_wb++;
               wb_addr = bus.mem_addr_o;
               wb_data = bus.mem_data_o;
            end else begin
               rd_addr = bus.mem_addr_o;
               m_rdata = line_of(bus.mem_addr_o);
            end
         end
      end else cnt = 0;
   end
   task automatic request(input logic [31:0] a, input logic [31:0] d, input logic rd,
                          input logic wr, output int stalls);
      @(negedge clk);
      bus.cpu_addr_i  = a;
      bus.cpu_data_i  = d;
      bus.cpu_read_i  = rd;
      bus.cpu_write_i = wr;
      #1;
      stalls = 0;
      while (bus.cpu_stall_o && stalls < 100) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      if (stalls >= 100) check("req_timeout", v_t'(bus.cpu_stall_o), v_t'(0));
   endtask
   task automatic idle_cpu();
      @(negedge clk);
      bus.cpu_read_i  = 1'b0;
      bus.cpu_write_i = 1'b0;
   endtask
   int   st, wr0, waited;
   v_t   exp44, exp240;
   initial begin
      bus.cpu_addr_i = '0; bus.cpu_data_i = '0; bus.cpu_read_i = 1'b0; bus.cpu_write_i = 1'b0;
      auto_mem = 1'b1; man_ack = 1'b0; m_ack = 1'b0; m_rdata = '0; sram_clr = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_stall", v_t'(bus.cpu_stall_o), v_t'(0));
      check("rst_mem_en", v_t'(bus.mem_enable_o), v_t'(0));
      check("rst_mem_wr", v_t'(bus.mem_write_o), v_t'(0));
      check("rst_cache_wr", v_t'(bus.cache_write_o), v_t'(0));
      check("rst_cpu_data", v_t'(bus.cpu_data_o), v_t'(0));
      @(negedge clk);
      rst = 1'b0;
      sram_clr = 1'b0;
      request(32'h40, 32'h0, 1'b1, 1'b0, st);
      check("cold_stall", v_t'(st), v_t'(8));
      check("cold_rd_addr", v_t'(rd_addr), v_t'(32'h40));
      check("cold_no_wb", v_t'(n_wb), v_t'(0));
      check("cold_data", v_t'(bus.cpu_data_o), v_t'(32'hA000_0040));
      @(negedge clk);
      bus.cpu_addr_i = 32'h48;
      #1;
      check("hit48_data", v_t'(bus.cpu_data_o), v_t'(32'hDEAD_BEEF));
      check("hit48_stall", v_t'(bus.cpu_stall_o), v_t'(0));
      check("hit48_index", v_t'(bus.cache_addr_o), v_t'(2));
      idle_cpu();
      request(32'h40, 32'h0, 1'b1, 1'b0, st);
      check("rehit_stall", v_t'(st), v_t'(0));
      check("rehit_data", v_t'(bus.cpu_data_o), v_t'(32'hA000_0040));
      check("rehit_mem_en", v_t'(bus.mem_enable_o), v_t'(0));
      check("rehit_no_wr", v_t'(bus.cache_write_o), v_t'(0));
      idle_cpu();
      exp44 = line_of(32'h40);
      exp44[63:32] = 32'h1234_5678;
      request(32'h44, 32'h1234_5678, 1'b0, 1'b1, st);
      check("st44_stall", v_t'(st), v_t'(0));
      check("st44_wr", v_t'(bus.cache_write_o), v_t'(1));
      check("st44_tag", v_t'(bus.cache_tag_o), v_t'(25'h180_0000));
      check("st44_line", bus.cache_data_o, exp44);
      idle_cpu();
      request(32'h44, 32'h0, 1'b1, 1'b0, st);
      check("ld44_data", v_t'(bus.cpu_data_o), v_t'(32'h1234_5678));
      idle_cpu();
      request(32'h240, 32'h55AA_55AA, 1'b0, 1'b1, st);
      check("st240_stall", v_t'(st), v_t'(8));
      check("st240_no_wb", v_t'(n_wb), v_t'(0));
      check("st240_wr", v_t'(bus.cache_write_o), v_t'(1));
      check("st240_tag", v_t'(bus.cache_tag_o), v_t'(25'h180_0001));
      idle_cpu();
      request(32'h440, 32'h0, 1'b1, 1'b0, st);
      check("dirty_stall", v_t'(st), v_t'(13));
      check("dirty_n_wb", v_t'(n_wb), v_t'(1));
      check("dirty_wb_addr", v_t'(wb_addr), v_t'(32'h40));
      check("dirty_wb_data", wb_data, exp44);
      check("dirty_rd_addr", v_t'(rd_addr), v_t'(32'h440));
      check("dirty_data", v_t'(bus.cpu_data_o), v_t'(32'hA000_0440));
      idle_cpu();
      exp240 = line_of(32'h240);
      exp240[31:0]  = 32'h55AA_55AA;
      exp240[63:32] = 32'hCAFE_F00D;
      request(32'h244, 32'hCAFE_F00D, 1'b1, 1'b1, st);
      check("rw_stall", v_t'(st), v_t'(0));
      check("rw_wr", v_t'(bus.cache_write_o), v_t'(1));
      check("rw_tag", v_t'(bus.cache_tag_o), v_t'(25'h180_0001));
      check("rw_line", bus.cache_data_o, exp240);
      idle_cpu();
      auto_mem = 1'b0;
      @(negedge clk);
      bus.cpu_addr_i = 32'h800;
      bus.cpu_read_i = 1'b1;
      #1;
      waited = 0;
      while (!(bus.mem_enable_o && !bus.mem_write_o) && waited < 20) begin
         waited++;
         @(negedge clk);
         #1;
      end
      if (waited >= 20) check("refill_timeout", v_t'(bus.mem_enable_o), v_t'(1));
      check("rf_addr", v_t'(bus.mem_addr_o), v_t'(32'h800));
      wr0 = n_wr;
      @(negedge clk);
      rst = 1'b1;
      bus.cpu_read_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      man_ack = 1'b1;
      #1;
      check("rstrf_stall", v_t'(bus.cpu_stall_o), v_t'(0));
      check("rstrf_mem_en", v_t'(bus.mem_enable_o), v_t'(0));
      check("rstrf_mem_wr", v_t'(bus.mem_write_o), v_t'(0));
      check("rstrf_mem_addr", v_t'(bus.mem_addr_o), v_t'(0));
      check("rstrf_cache_wr", v_t'(bus.cache_write_o), v_t'(0));
      check("rstrf_cpu_data", v_t'(bus.cpu_data_o), v_t'(0));
      @(negedge clk);
      man_ack = 1'b0;
      #1;
      check("ack_ignored_en", v_t'(bus.mem_enable_o), v_t'(0));
      check("ack_ignored_stall", v_t'(bus.cpu_stall_o), v_t'(0));
      repeat (2) @(negedge clk);
      check("rstrf_no_sram_wr", v_t'(n_wr), v_t'(wr0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Data-cache controller sitting between the CPU memory stage and the 2-way dcache SRAM plus the off-chip data memory. It decodes CPU load/store requests into set index, tag and word offset. It serves hits in zero stall cycles and merges store words into lines. On a miss it runs a write-back/refill FSM against memory with a valid/ack handshake. It owns the valid/dirty bits carried in the SRAM tag field.

Parameters:
ADDR_W, 32, CPU byte-address width
INDEX_W, 4, set-index bits (16 sets)
OFFSET_W, 5, byte offset within a line (32-byte line)
LINE_W, 256, cache line width in bits
WORD_W, 32, CPU data word width
TAG_W, ADDR_W-INDEX_W-OFFSET_W (23), address tag width; SRAM tag field = TAG_W+2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cpu_addr_i  in  ADDR_W  CPU byte address
cpu_data_i  in  WORD_W  store data
cpu_read_i  in  1  load request
cpu_write_i  in  1  store request
cpu_data_o  out  WORD_W  load data
cpu_stall_o  out  1  stall CPU pipeline
mem_enable_o  out  1  memory request valid
mem_write_o  out  1  1=write-back, 0=refill read
mem_addr_o  out  ADDR_W  line-aligned memory address
mem_data_o  out  LINE_W  write-back line
mem_data_i  in  LINE_W  refill line
mem_ack_i  in  1  one-cycle completion pulse
cache_enable_o  out  1  SRAM access enable
cache_write_o  out  1  SRAM write strobe
cache_addr_o  out  INDEX_W  set index
cache_tag_o  out  TAG_W+2  {valid, dirty, tag}
cache_data_o  out  LINE_W  line to write
cache_tag_i  in  TAG_W+2  SRAM tag out (hit way, or LRU victim on miss)
cache_data_i  in  LINE_W  SRAM data out
cache_hit_i  in  1  SRAM hit

Behaviour:
- Address split: tag=addr[31:9], index=addr[8:5], word=addr[4:2]; addr[1:0] ignored.
- req = cpu_read_i | cpu_write_i. Both asserted is treated as a store.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE. Reset → IDLE, regardless of state. Outstanding mem_ack_i is ignored after reset.
- Reset values: cpu_stall_o=0, mem_enable_o=0, mem_write_o=0, cache_write_o=0, cpu_data_o=0, and all registered address/data = 0.
- IDLE:
  - cache_enable_o=req, cache_tag_o={1,0,tag} for lookup.
  - cpu_stall_o = req & ~cache_hit_i (combinational).
  - Read hit: cpu_data_o = cache_data_i word[word], same cycle.
  - Write hit: cache_write_o=1 same cycle. cache_data_o = cache_data_i with the selected word replaced by cpu_data_i. cache_tag_o={1,1,tag}.
  - Miss → MISS.
- MISS: latch the victim {tag_i, data_i}.
  - If victim valid&dirty → WRITEBACK.
  - Else → REFILL.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1, mem_addr_o={victim_tag,index,5'b0}, mem_data_o=victim line.
  - These are held stable until mem_ack_i; on ack → REFILL.
- REFILL:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o={tag,index,5'b0}, held until mem_ack_i.
  - On ack, latch mem_data_i → REFILL_DONE.
- REFILL_DONE:
  - cache_enable_o=1, cache_write_o=1, cache_tag_o={1,0,tag}, cache_data_o=refilled line → IDLE.
  - The request is re-looked-up in IDLE and now hits. A pending store then merges and sets dirty.
- mem_enable_o deasserts the cycle after ack is sampled. mem_ack_i outside WRITEBACK/REFILL is ignored.
- cpu_stall_o=1 in every non-IDLE state.
- CPU request inputs are held stable while stalled (CPU contract); the controller does not re-latch them.
- Miss latency:
  - Clean miss: stall = 1 (IDLE detect) + 1 (MISS) + memory latency + 1 (REFILL_DONE) + 0 (hit) cycles.
  - Dirty miss adds a full memory latency.

Decomposition:
- Package dcache_pkg: address-split widths, TAG_W, the state enum, tag-field bit positions (VALID_BIT=24, DIRTY_BIT=23), and a word-merge function.
- One natural sub-module: dcache_word_merge (line, word index, data → merged line; word extract).

Test Plan:
- Cold load of 0x0000_0040 with memory latency 5 and mem_data_i word2=0xDEADBEEF → no write-back. Expect mem_addr_o=0x40, mem_write_o=0, stall for 8 cycles, then cpu_data_o=0xDEADBEEF on addr 0x48.
- Repeat the same load → cache_hit_i=1, cpu_stall_o=0, data returned in the same cycle, mem_enable_o stays 0.
- Store 0x12345678 to 0x44 (hit) → single-cycle cache_write_o. cache_tag_o dirty bit=1. Word1 of the line replaced, other words unchanged.
- Fill both ways of set 2 dirty, then load a third tag to set 2. Expect a WRITEBACK of the victim line to {victim_tag,2,0} with its exact data, followed by REFILL of the new address.
- Assert rst_i during REFILL with mem_ack_i arriving the next cycle. Expect IDLE with all outputs reset, ack ignored, and no SRAM write.
- Load and store asserted together to the same hit address. Expect it treated as a store: SRAM written and dirty set.
